// File: rtl/usb_nrzi_tx_encoder.sv
// usb_nrzi_tx_encoder
//
// Transmit-side USB line encoder. It takes an NRZ bit stream (LSB-first,
// already serialised by the packet layer) over a valid/ready handshake,
// inserts a stuffed 0 after STUFF_LEN consecutive 1s, NRZI-encodes the
// result and closes the packet with an EOP: SE0 for EOP_SE0_BITS bit
// times followed by one J bit. Every state change happens only on
// i_bit_en cycles, so the line driver sees one symbol per bit strobe.
//
// Handshake: o_ready is combinational and is only ever high on a strobe
// cycle. A bit is transferred on a clock edge where i_valid & o_ready.
// The source holds i_data/i_last stable while i_valid is high until that
// transfer happens; outside o_ready cycles the inputs are ignored.
//
// Ports
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset
//   i_bit_en    one-cycle bit-time strobe
//   i_data      NRZ data bit
//   i_valid     i_data/i_last valid
//   i_last      current bit is the final bit of the packet
//   o_ready     bit accepted on i_valid & o_ready (combinational)
//   o_data      NRZI line level (1 = J, 0 = K), 0 during SE0
//   o_se0       drive SE0
//   o_valid     transmitter enabled, line symbol driven
//   o_underrun  one-cycle pulse: source ran dry in the middle of a packet

module usb_nrzi_tx_encoder #(
  parameter int STUFF_LEN    = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_bit_en,
  input  logic i_data,
  input  logic i_valid,
  input  logic i_last,
  output logic o_ready,
  output logic o_data,
  output logic o_se0,
  output logic o_valid,
  output logic o_underrun
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DATA    = 2'd1;
  localparam logic [1:0] ST_EOP_SE0 = 2'd2;
  localparam logic [1:0] ST_EOP_J   = 2'd3;

  localparam logic [2:0] STUFF_CNT = 3'(STUFF_LEN);
  localparam logic [1:0] SE0_BITS  = 2'(EOP_SE0_BITS);

  logic [1:0] r_state;
  logic [2:0] r_ones_cnt;
  logic       r_last_seen;
  logic [1:0] r_se0_cnt;

  logic       w_stuff_due;
  logic       w_in_idle;
  logic       w_in_data;

  assign w_stuff_due = (r_ones_cnt == STUFF_CNT);
  assign w_in_idle   = (r_state == ST_IDLE);
  assign w_in_data   = (r_state == ST_DATA);

  // No input is taken on a stuff slot or once the final bit has been seen;
  // the upstream source simply keeps holding its bit.
  assign o_ready = i_bit_en & (w_in_idle | (w_in_data & ~w_stuff_due & ~r_last_seen));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_ones_cnt  <= 3'd0;
      r_last_seen <= 1'b0;
      r_se0_cnt   <= 2'd0;
      o_data      <= 1'b1;
      o_se0       <= 1'b0;
      o_valid     <= 1'b0;
      o_underrun  <= 1'b0;
    end else begin
      // Underrun is a single-cycle pulse regardless of strobe spacing.
      o_underrun <= 1'b0;
      if (i_bit_en) begin
        case (r_state)
          ST_IDLE: begin
            if (i_valid) begin
              // Line idles at J (1): a 1 holds J, a 0 toggles to K.
              o_data      <= i_data;
              o_se0       <= 1'b0;
              o_valid     <= 1'b1;
              r_ones_cnt  <= i_data ? 3'd1 : 3'd0;
              r_last_seen <= i_last;
              r_state     <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (w_stuff_due) begin
              // Stuffed 0 goes out even after the final bit, before the EOP.
              o_data     <= ~o_data;
              r_ones_cnt <= 3'd0;
            end else if (r_last_seen) begin
              o_se0     <= 1'b1;
              o_data    <= 1'b0;
              r_se0_cnt <= 2'd1;
              r_state   <= ST_EOP_SE0;
            end else if (i_valid) begin
              o_data      <= i_data ? o_data : ~o_data;
              r_ones_cnt  <= i_data ? (r_ones_cnt + 3'd1) : 3'd0;
              r_last_seen <= i_last;
            end else begin
              // Source ran dry mid-packet: flag it and terminate with an EOP.
              o_underrun <= 1'b1;
              o_se0      <= 1'b1;
              o_data     <= 1'b0;
              r_se0_cnt  <= 2'd1;
              r_state    <= ST_EOP_SE0;
            end
          end
          ST_EOP_SE0: begin
            if (r_se0_cnt < SE0_BITS) begin
              r_se0_cnt <= r_se0_cnt + 2'd1;
            end else begin
              o_se0   <= 1'b0;
              o_data  <= 1'b1;
              r_state <= ST_EOP_J;
            end
          end
          ST_EOP_J: begin
            o_valid     <= 1'b0;
            o_data      <= 1'b1;
            r_ones_cnt  <= 3'd0;
            r_last_seen <= 1'b0;
            r_state     <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_nrzi_tx_encoder.sv
// Bench for usb_nrzi_tx_encoder. Expected line symbols come from a
// stream-level model: stuffing by run length, NRZI by level toggling, then
// a fixed EOP tail. Each expected entry is {ready, underrun, valid, se0, data}
// for the symbol produced by one bit strobe.

module tb_usb_nrzi_tx_encoder;

  localparam int STUFF_LEN    = 6;
  localparam int EOP_SE0_BITS = 2;
  localparam logic [4:0] IDLE_E = 5'b10001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_bit_en = 1'b0;
  logic i_data = 1'b0;
  logic i_valid = 1'b0;
  logic i_last = 1'b0;
  logic o_ready, o_data, o_se0, o_valid, o_underrun;

  always #5 clk = ~clk;

  usb_nrzi_tx_encoder #(
    .STUFF_LEN    (STUFF_LEN),
    .EOP_SE0_BITS (EOP_SE0_BITS)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_bit_en   (i_bit_en),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_last     (i_last),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_se0      (o_se0),
    .o_valid    (o_valid),
    .o_underrun (o_underrun)
  );

  // ---------------- scoreboard state ----------------
  logic [4:0] exp_q[$];
  logic [4:0] mdl_q[$];
  logic [2:0] held = 3'b001;
  bit         chk_en = 1'b0;
  bit         noise_en = 1'b0;
  int         strobe_period = 1;
  int         strobe_cnt = 0;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void build_model(input logic [63:0] bits, input int n, input bit und);
    logic lvl = 1'b1;
    int   run = 0;
    for (int i = 0; i < n; i++) begin
      if (!bits[i]) lvl = ~lvl;
      mdl_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, lvl});
      run = bits[i] ? run + 1 : 0;
      if (run == STUFF_LEN) begin
        lvl = ~lvl;
        mdl_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, lvl});
        run = 0;
      end
    end
    // First SE0 slot: accepting strobe only when the source ran dry.
    mdl_q.push_back({und, und, 1'b1, 1'b1, 1'b0});
    for (int i = 1; i < EOP_SE0_BITS; i++) mdl_q.push_back(5'b00110);
    mdl_q.push_back(5'b00101);
    mdl_q.push_back(5'b00001);
  endfunction

  // ---------------- strobe generator ----------------
  initial begin
    forever begin
      @(posedge clk); #2;
      strobe_cnt++;
      if (strobe_cnt >= strobe_period) begin
        strobe_cnt = 0;
        i_bit_en = 1'b1;
      end else begin
        i_bit_en = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin : compare_proc
    logic       pre_en;
    logic       pre_ready;
    logic [4:0] e;
    logic [4:0] act;
    forever begin
      @(negedge clk); #1;
      if (!chk_en) continue;
      pre_en    = i_bit_en;
      pre_ready = o_ready;
      @(posedge clk); #1;
      if (!chk_en) continue;
      act = {pre_ready, o_underrun, o_valid, o_se0, o_data};
      if (pre_en) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_E;
        held = e[2:0];
        check("strobe_sym", act, e);
      end else begin
        check("hold_sym", act, {2'b00, held});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_empty(input int limit);
    int n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (exp_q.size() != 0 && n < limit);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic send_bit(input logic b, input logic last, output bit ok);
    logic acc;
    ok = 1'b0;
    for (int guard = 0; guard < 400; guard++) begin
      @(negedge clk);
      if (i_bit_en || !noise_en) begin
        i_valid = 1'b1; i_data = b; i_last = last;
      end else begin
        i_valid = 1'($urandom_range(0, 1));
        i_data  = 1'($urandom_range(0, 1));
        i_last  = 1'($urandom_range(0, 1));
      end
      #1 acc = i_valid & o_ready;
      @(posedge clk);
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_packet(input logic [63:0] bits, input int n, input bit und);
    bit ok;
    wait_empty(3000);
    mdl_q.delete();
    build_model(bits, n, und);
    foreach (mdl_q[k]) exp_q.push_back(mdl_q[k]);
    for (int i = 0; i < n; i++) begin
      send_bit(bits[i], (!und && i == n - 1), ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout bit=%0d actual=not_accepted required=accepted", i);
        break;
      end
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic pin_model();
    logic [7:0] lv;
    // SYNC 0x80: levels 0,1,0,1,0,1,0,0 then SE0,SE0,J,idle.
    mdl_q.delete(); build_model(64'h80, 8, 1'b0);
    lv = '0;
    for (int i = 0; i < 8; i++) lv[i] = mdl_q[i][0];
    check("pin_sync_levels", lv, 8'h2A);
    check("pin_sync_len", mdl_q.size(), 12);
    // Seven 1s: six J, stuffed K, 7th bit holds K.
    mdl_q.delete(); build_model(64'h7F, 7, 1'b0);
    lv = '0;
    for (int i = 0; i < 8; i++) lv[i] = mdl_q[i][0];
    check("pin_stuff7_levels", lv, 8'h3F);
    check("pin_stuff7_slot", mdl_q[6], 5'b00100);
    check("pin_stuff7_se0", mdl_q[8], 5'b00110);
    // Six 1s: stuff before EOP.
    mdl_q.delete(); build_model(64'h3F, 6, 1'b0);
    check("pin_stuff6_stuff", mdl_q[6], 5'b00100);
    check("pin_stuff6_len", mdl_q.size(), 11);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main_proc
    logic [63:0] rbits;
    int          rlen;
    bit          rund;

    pin_model();

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_valid", o_valid, 1'b0);
    check("rst_data", o_data, 1'b1);
    check("rst_se0", o_se0, 1'b0);
    check("rst_underrun", o_underrun, 1'b0);
    i_rst_n = 1'b1;
    held    = 3'b001;
    chk_en  = 1'b1;

    // SYNC with a strobe every 4th clock.
    strobe_period = 4;
    send_packet(64'h80, 8, 1'b0);

    // Stuffing and stuff-before-EOP, back to back strobes.
    strobe_period = 1;
    send_packet(64'h7F, 7, 1'b0);
    send_packet(64'h3F, 6, 1'b0);
    send_packet(64'h80, 8, 1'b0);

    // Gapped strobes with i_valid toggled between strobes.
    strobe_period = 5;
    noise_en = 1'b1;
    send_packet(64'h80, 8, 1'b0);
    send_packet(64'h7F, 7, 1'b0);
    noise_en = 1'b0;

    // Underrun after three bits.
    strobe_period = 2;
    send_packet(64'h5, 3, 1'b1);

    // Reset during the 5th data bit of a SYNC.
    strobe_period = 4;
    wait_empty(3000);
    mdl_q.delete();
    build_model(64'h80, 8, 1'b0);
    foreach (mdl_q[k]) exp_q.push_back(mdl_q[k]);
    for (int i = 0; i < 4; i++) begin
      bit ok;
      send_bit(1'b0, 1'b0, ok);
      check("mid_rst_accept", ok, 1'b1);
    end
    @(negedge clk);
    i_valid = 1'b1; i_data = 1'b0; i_last = 1'b0;
    @(posedge clk); #3;
    chk_en = 1'b0;
    i_rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_valid", o_valid, 1'b0);
    check("mid_rst_data", o_data, 1'b1);
    check("mid_rst_se0", o_se0, 1'b0);
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    held    = 3'b001;
    chk_en  = 1'b1;
    send_packet(64'h80, 8, 1'b0);

    // Randomized packets: 1-biased data for frequent stuffing.
    for (int p = 0; p < 14; p++) begin
      rlen = $urandom_range(1, 24);
      rbits = '0;
      for (int i = 0; i < rlen; i++) rbits[i] = ($urandom_range(0, 3) != 0);
      rund = ($urandom_range(0, 3) == 0);
      strobe_period = $urandom_range(1, 4);
      noise_en = ($urandom_range(0, 1) == 1) && !rund;
      send_packet(rbits, rlen, rund);
    end
    noise_en = 1'b0;

    wait_empty(3000);
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/usb_nrzi_tx_encoder.md
Name: usb_nrzi_tx_encoder

Overview:
- Transmit-side counterpart to the PHY NRZI receive path.
- Accepts a serial NRZ bit stream (LSB-first, already serialised by the packet layer) over a valid/ready handshake.
- Performs USB bit stuffing (a 0 inserted after six consecutive 1s), NRZI-encodes the result, and appends the EOP: SE0 for EOP_SE0_BITS bit times, then one J bit.
- Output feeds the line driver, one symbol per bit-strobe.

Parameters:
- STUFF_LEN, 6: consecutive 1 data bits that force insertion of a stuffed 0.
- EOP_SE0_BITS, 2: SE0 bit times in EOP (legal range 1..3).

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset: asynchronous, active-low.
- i_bit_en  input  1  bit-time strobe, one i_clk pulse per USB bit; state advances only on these cycles.
- i_data  input  1  NRZ data bit.
- i_valid  input  1  i_data/i_last valid.
- i_last  input  1  current bit is final bit of packet.
- o_ready  output  1  combinational; bit accepted on i_valid & o_ready.
- o_data  output  1  NRZI line level (1 = J, 0 = K); 0 during SE0.
- o_se0  output  1  drive SE0.
- o_valid  output  1  line symbol is driven (transmitter enabled).
- o_underrun  output  1  one-cycle pulse: i_valid low in DATA on a bit slot.

Behaviour:
- Reset (async, any state, including mid-packet):
  - state=IDLE, o_data=1, o_se0=0, o_valid=0, o_underrun=0, ones_cnt=0, last_seen=0.
  - Any partial packet is dropped; no EOP is sent.
- Outputs are registered and hold between i_bit_en pulses. Latency: a bit accepted on strobe N appears on outputs the cycle after strobe N.
- o_ready = i_bit_en & (state==IDLE | (state==DATA & ones_cnt!=STUFF_LEN & !last_seen)).
- Encoding rule for each emitted bit b: o_data <= b ? o_data : ~o_data. A 0 toggles the level; a 1 holds it.
- ones_cnt (3 bits): +1 on an emitted data 1; cleared on an emitted data 0 or a stuffed bit. It never exceeds STUFF_LEN.
- IDLE:
  - On i_bit_en & i_valid: accept, encode starting from level 1 (J), o_valid<=1, set last_seen=i_last, go DATA.
  - Otherwise outputs hold at idle values.
- DATA, on each i_bit_en, first match wins:
  - ones_cnt==STUFF_LEN: emit stuffed 0 (toggle), ones_cnt<=0. No input is accepted. This applies even when last_seen is set (stuff before EOP).
  - last_seen: go EOP_SE0. Outputs o_se0<=1, o_data<=0, cnt<=1.
  - i_valid: accept and encode; last_seen<=i_last.
  - !i_valid: o_underrun pulses 1 cycle, then abort to EOP_SE0 as above.
- EOP_SE0, on i_bit_en:
  - cnt<EOP_SE0_BITS: cnt+1, SE0 held.
  - Else: o_se0<=0, o_data<=1 (J), go EOP_J.
- EOP_J, on i_bit_en: o_valid<=0, o_data<=1, ones_cnt<=0, last_seen<=0, go IDLE.
  - A new packet's first bit may be accepted at the earliest on the following strobe.
- i_valid/i_data/i_last are ignored outside o_ready cycles. The upstream source must hold them until accepted.
- i_bit_en low: no state change, no acceptance, no underrun detection.

Test Plan:
- SYNC: bits 0,0,0,0,0,0,0,1 (last on 8th), strobe every 4th clk -> o_data 0,1,0,1,0,1,0,0, then o_se0=1 for 2 strobes, J (o_data=1) 1 strobe, then o_valid=0; o_ready never low within the packet.
- Stuffing: 7 ones, last=1 on 7th -> levels 1×6, stuffed toggle to 0, 7th bit 0, then EOP; o_ready=0 on the stuff strobe; total symbols = 8 + 3.
- Stuff before EOP: exactly 6 ones, last on 6th -> six 1s, stuffed 0 (level 0), then SE0×2, J.
- Gapped strobes/backpressure: i_bit_en 1-in-5 and i_valid toggled between strobes (high on strobes) -> identical symbol stream to the back-to-back case; outputs stable between strobes.
- Underrun: 3 bits sent, i_valid=0 on 4th strobe -> o_underrun one-cycle pulse, then SE0×2, J, IDLE.
- Reset mid-packet: assert i_rst_n=0 asynchronously during the 5th data bit -> outputs immediately o_valid=0, o_data=1, o_se0=0. After release, a new 0x80 SYNC encodes exactly as in the first scenario with no residual ones_cnt.
